// File: rtl/dram_fifo_burst_sched.sv
// Burst scheduler between the staging FIFOs and the DRAM ring buffer. It issues one DMA
// burst command at a time and owns the ring pointers and the committed DRAM occupancy.
//   state | meaning
//   IDLE  | evaluate write/read eligibility, register the granted command
//   ISSUE | cmd_tvalid held until cmd_tready
//   WAIT  | command accepted, waiting for done_stb
//   DRAIN | clear hit an in-flight command: finish handshake, swallow its done_stb
module dram_fifo_burst_sched #(
    parameter int SR_BASE         = 0,
    parameter int BURST_LOG2      = 8,
    parameter int DRAM_WORDS_LOG2 = 24,
    parameter int OCC_W           = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 set_stb,
    input  logic [7:0]                           set_addr,
    input  logic [31:0]                          set_data,
    output logic [31:0]                          rb_data,
    input  logic [OCC_W-1:0]                     in_occ,
    input  logic [OCC_W-1:0]                     out_space,
    output logic [DRAM_WORDS_LOG2+BURST_LOG2:0]  cmd_tdata,
    output logic                                 cmd_tvalid,
    input  logic                                 cmd_tready,
    input  logic                                 done_stb,
    output logic [DRAM_WORDS_LOG2:0]             dram_occ,
    output logic                                 dram_full,
    output logic                                 dram_empty
);
    localparam int N  = DRAM_WORDS_LOG2;
    localparam int B  = BURST_LOG2;
    localparam int CW = ((N + 1 > OCC_W) ? N + 1 : OCC_W) + 1;
    localparam logic [CW-1:0] MAX_BURST = CW'(1) << B;
    localparam logic [CW-1:0] RING      = CW'(1) << N;
    localparam logic [7:0]    SR_CTRL   = 8'(SR_BASE + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DRAIN = 2'd3} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  wr_ptr, rd_ptr;
    logic [11:0]   timeout, timer;
    logic          pri_rd, err_sticky;
    logic          cmd_rd;
    logic [N-1:0]  cmd_addr;
    logic [B-1:0]  cmd_len_m1;
    logic [B:0]    cmd_len;
    logic [CW-1:0] wlen, rlen;
    logic          clear, hs, done_ok, spurious, expired;
    logic          w_elig, r_elig, grant_w, grant_r;
    logic [24:0]   occ_rb;
    logic          unused_ok;

    function automatic logic [CW-1:0] min2(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    assign clear      = set_stb && (set_addr == SR_CTRL) && set_data[0];
    assign hs         = cmd_tvalid && cmd_tready;
    assign cmd_len    = (B+1)'(cmd_len_m1) + (B+1)'(1);
    assign cmd_tdata  = {cmd_rd, cmd_addr, cmd_len_m1};
    assign dram_full  = (CW'(dram_occ) == RING);
    assign dram_empty = (dram_occ == '0);
    assign occ_rb     = 25'(dram_occ);
    assign rb_data    = {2'(state), err_sticky, 4'b0, occ_rb};
    assign unused_ok  = ^{set_data[31:16], set_data[3:1]};

    always_comb begin
        wlen     = min2(min2(CW'(in_occ), MAX_BURST), min2(RING - CW'(wr_ptr), RING - CW'(dram_occ)));
        rlen     = min2(min2(CW'(dram_occ), MAX_BURST), RING - CW'(rd_ptr));
        expired  = (timer >= timeout);
        w_elig   = (wlen != '0) && ((CW'(in_occ) >= MAX_BURST) || expired);
        r_elig   = (rlen != '0) && (CW'(out_space) >= rlen);
        grant_r  = 1'b0;
        grant_w  = 1'b0;
        if (state == IDLE && !clear) begin
            grant_r = r_elig && (!w_elig || pri_rd);
            grant_w = w_elig && !grant_r;
        end
        // a done_stb arriving while the handshake is still pending is not ours
        done_ok  = done_stb && ((state == WAIT) || (state == DRAIN && !cmd_tvalid));
        spurious = done_stb && !done_ok;
        state_nxt = state;
        case (state)
            IDLE:    if (grant_w || grant_r) state_nxt = ISSUE;
            ISSUE:   if (clear) state_nxt = DRAIN;
                     else if (hs) state_nxt = WAIT;
            WAIT:    if (done_ok) state_nxt = IDLE;
                     else if (clear) state_nxt = DRAIN;
            DRAIN:   if (done_ok) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout    <= '0;
            timer      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            dram_occ   <= '0;
            pri_rd     <= 1'b0;
            err_sticky <= 1'b0;
            cmd_tvalid <= 1'b0;
            cmd_rd     <= 1'b0;
            cmd_addr   <= '0;
            cmd_len_m1 <= '0;
        end else begin
            if (set_stb && set_addr == SR_CTRL) timeout <= set_data[15:4];
            if (hs) cmd_tvalid <= 1'b0;
            if (grant_w || grant_r) begin
                cmd_tvalid <= 1'b1;
                cmd_rd     <= grant_r;
                cmd_addr   <= grant_r ? rd_ptr : wr_ptr;
                cmd_len_m1 <= B'((grant_r ? rlen : wlen) - CW'(1));
            end
            if (clear) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                dram_occ   <= '0;
                timer      <= '0;
                pri_rd     <= 1'b0;
                err_sticky <= 1'b0;
            end else begin
                if (grant_w || grant_r) pri_rd <= grant_w;
                // reads reserve their words at handshake, writes commit at completion
                if (hs && state == ISSUE) begin
                    if (cmd_rd) begin
                        rd_ptr   <= rd_ptr + N'(cmd_len);
                        dram_occ <= dram_occ - (N+1)'(cmd_len);
                    end else begin
                        wr_ptr   <= wr_ptr + N'(cmd_len);
                    end
                end
                if (done_ok && state == WAIT && !cmd_rd) dram_occ <= dram_occ + (N+1)'(cmd_len);
                if (spurious) err_sticky <= 1'b1;
                if (grant_w || in_occ == '0) timer <= '0;
                else if (state == IDLE && CW'(in_occ) < MAX_BURST && timer != '1) timer <= timer + 12'd1;
            end
        end
    end
endmodule
